// File: rtl/line_mem_pkg.sv
// ---------------------------------------------------------------------------
// line_mem_pkg : shared constants and enums for the line memory model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package line_mem_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_ERR   = 2'd2
  } op_t;

endpackage

`default_nettype wire

// File: rtl/line_mem_array.sv
// ---------------------------------------------------------------------------
// line_mem_array : line storage, synchronous write, combinational read. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module line_mem_array #(
  parameter int LINE_WIDTH = 256,
  parameter int INDEX_BITS = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_idx,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic [LINE_WIDTH-1:0] o_rdata
);

  // Contents survive rst on purpose; only the controller is reset.
  logic [LINE_WIDTH-1:0] r_mem [2**INDEX_BITS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

`default_nettype wire

// File: rtl/line_mem_model.sv
// ---------------------------------------------------------------------------
// line_mem_model : fixed-latency cache-line memory slave with one-cycle resp.
// Optional protocol checker enabled by LINE_MEM_PROTOCOL_CHECK_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module line_mem_model #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 10,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [LINE_WIDTH-1:0] mem_wdata,
  output logic [LINE_WIDTH-1:0] mem_rdata,
  output logic                  mem_resp,
  output logic                  mem_error
);

  import line_mem_pkg::*;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t                  r_state;
  op_t                     r_op;
  logic [7:0]              r_cnt;
  logic [INDEX_BITS-1:0]   r_idx;
  logic [LINE_WIDTH-1:0]   r_wdata;

  logic                    w_req;
  logic [INDEX_BITS-1:0]   w_idx;
  op_t                     w_op;
  logic                    w_we;
  logic [LINE_WIDTH-1:0]   w_arr_rdata;

  assign w_req = mem_read | mem_write;
  assign w_idx = mem_address[OFFSET_BITS +: INDEX_BITS];

`ifdef LINE_MEM_PROTOCOL_CHECK_EN
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_addr;

  assign w_op      = (mem_read && mem_write) ? OP_ERR : (mem_write ? OP_WRITE : OP_READ);
  assign mem_error = r_err;
`else
  logic w_unused_addr;

  assign w_op          = mem_write ? OP_WRITE : OP_READ;
  assign mem_error     = 1'b0;
  assign w_unused_addr = ^{mem_address[OFFSET_BITS-1:0],
                           mem_address[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= OP_READ;
      r_cnt   <= 8'd0;
      r_idx   <= '0;
      r_wdata <= '0;
`ifdef LINE_MEM_PROTOCOL_CHECK_EN
      r_err   <= 1'b0;
      r_addr  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_op    <= w_op;
            r_idx   <= w_idx;
            r_wdata <= mem_wdata;
            r_cnt   <= LAT_M1;
            r_state <= (LATENCY == 1) ? RESP : BUSY;
`ifdef LINE_MEM_PROTOCOL_CHECK_EN
            r_addr  <= mem_address;
            if (mem_read && mem_write) begin
              r_err <= 1'b1;
            end
`endif
          end
        end
        BUSY: begin
          // Leaving on count 1 puts resp in the LATENCY-th cycle after acceptance.
          if (r_cnt <= 8'd1) begin
            r_cnt   <= 8'd0;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
`ifdef LINE_MEM_PROTOCOL_CHECK_EN
          if (!w_req || (mem_address != r_addr)) begin
            r_err <= 1'b1;
          end
`endif
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // rst in the response cycle must also drop the pending write.
  assign w_we      = (r_state == RESP) && (r_op == OP_WRITE) && !rst;
  assign mem_resp  = (r_state == RESP);
  assign mem_rdata = (mem_resp && (r_op == OP_READ)) ? w_arr_rdata : '0;

  line_mem_array #(
    .LINE_WIDTH (LINE_WIDTH),
    .INDEX_BITS (INDEX_BITS)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_arr_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_line_mem_model.sv
// ---------------------------------------------------------------------------
// tb_line_mem_model : directed bench with a cycle-level behavioural model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_line_mem_model;

  localparam int LAT   = 4;
  localparam int DEPTH = 1024;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [31:0]  mem_address = '0;
  logic [255:0] mem_wdata = '0;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic         mem_error;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  line_mem_model #(
    .LINE_WIDTH (256),
    .ADDR_WIDTH (32),
    .INDEX_BITS (10),
    .LATENCY    (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .mem_error   (mem_error)
  );

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: one outstanding transaction, tracked by the edge number it was accepted on.
  logic [255:0] mem_m [DEPTH];
  int           e = 0;
  bit           m_valid = 0;
  bit           m_busy = 0;
  int           m_k = 0;
  int           m_op = 0;  // 0 read, 1 write, 2 error
  int           m_idx = 0;
  logic [31:0]  m_addr = '0;
  logic [255:0] m_wd = '0;
  bit           m_err = 0;
  bit           exp_resp = 0;
  logic [255:0] exp_rdata = '0;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  end

  always @(posedge clk) begin
    e++;
    if (rst) begin
      m_busy  = 0;
      m_err   = 0;
      m_valid = 1;
    end else if (m_busy) begin
      if (e == m_k + LAT) begin
        if (m_op == 1) mem_m[m_idx] = m_wd;
        m_busy = 0;
      end
`ifdef LINE_MEM_PROTOCOL_CHECK_EN
      else if (e < m_k + LAT && (!(mem_read || mem_write) || mem_address != m_addr)) begin
        m_err = 1;
      end
`endif
    end else if (mem_read || mem_write) begin
      m_busy = 1;
      m_k    = e;
      m_addr = mem_address;
      m_idx  = int'((mem_address >> 5) % DEPTH);
      m_wd   = mem_wdata;
      m_op   = mem_write ? 1 : 0;
`ifdef LINE_MEM_PROTOCOL_CHECK_EN
      if (mem_read && mem_write) begin
        m_op  = 2;
        m_err = 1;
      end
`endif
    end
    exp_resp  = m_busy && (e == m_k + LAT - 1);
    exp_rdata = (exp_resp && m_op == 0) ? mem_m[m_idx] : '0;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_resp",  {255'd0, mem_resp},  {255'd0, exp_resp});
      check("model_rdata", mem_rdata, exp_rdata);
      check("model_error", {255'd0, mem_error}, {255'd0, m_err});
    end
  end

  // Issue one request, measure latency, check data, then release.
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [255:0] wd, input logic [255:0] exp_rd, input string nm);
    int n;
    bit got;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = wd;
    n = 0; got = 0;
    while (!got && n < 3 * LAT + 10) begin
      @(posedge clk); #1;
      n++;
      if (mem_resp) got = 1;
    end
    check({nm, "_latency"}, 256'(n), 256'(LAT));
    if (got) check({nm, "_rdata"}, mem_rdata, exp_rd);
    @(negedge clk);
    mem_read = 0; mem_write = 0;
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  logic [255:0] c_a5;
  logic [255:0] c_11;
  logic [255:0] c_pat;

  initial begin
    int p1, p2;
    bit prev, twice;
    c_a5  = {32{8'hA5}};
    c_11  = {32{8'h11}};
    c_pat = {8{32'h0123_4567}} ^ {4{64'hDEAD_BEEF_0000_FFFF}};

    repeat (3) @(negedge clk);
    rst = 0;
    check("reset_resp",  {255'd0, mem_resp},  256'd0);
    check("reset_rdata", mem_rdata, 256'd0);
    check("reset_error", {255'd0, mem_error}, 256'd0);

    // Offset bits are ignored: 0x5F lands on the same line as 0x40.
    do_op(0, 1, 32'h0000_0040, c_a5, 256'd0, "wr_a5");
    do_op(1, 0, 32'h0000_005F, 256'd0, c_a5, "rd_a5");

    // 0x8000 aliases to index 0 with 10 index bits.
    do_op(0, 1, 32'h0000_0000, c_pat, 256'd0, "wr_alias");
    do_op(1, 0, 32'h0000_8000, 256'd0, c_pat, "rd_alias");

    // Held read: pulses at cycles LAT and 2*LAT+1, never adjacent.
    @(negedge clk);
    mem_read = 1; mem_address = 32'h0000_0040;
    p1 = 0; p2 = 0; prev = 0; twice = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (mem_resp && prev) twice = 1;
      if (mem_resp && p1 == 0) p1 = c;
      else if (mem_resp && p2 == 0) p2 = c;
      if (!mem_resp) check("held_gap_rdata", mem_rdata, 256'd0);
      prev = mem_resp;
    end
    check("held_first_pulse",  256'(p1), 256'd4);
    check("held_second_pulse", 256'(p2), 256'd9);
    check("held_no_adjacent",  {255'd0, twice}, 256'd0);
    @(negedge clk); mem_read = 0;
    repeat (2 * LAT + 4) @(negedge clk);

    // Reset two cycles into a write: nothing is committed, no response.
    do_op(0, 1, 32'h0000_0060, c_11, 256'd0, "wr_line3");
    @(negedge clk);
    mem_write = 1; mem_address = 32'h0000_0060; mem_wdata = '1;
    @(posedge clk); #1;
    check("rst_mid_resp0", {255'd0, mem_resp}, 256'd0);
    @(posedge clk); #1;
    check("rst_mid_resp1", {255'd0, mem_resp}, 256'd0);
    @(negedge clk); rst = 1; mem_write = 0;
    @(negedge clk); rst = 0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(posedge clk); #1;
      check("rst_mid_no_resp", {255'd0, mem_resp}, 256'd0);
    end
    do_op(1, 0, 32'h0000_0060, 256'd0, c_11, "rd_line3");
    check("default_error_low", {255'd0, mem_error}, 256'd0);

`ifdef LINE_MEM_PROTOCOL_CHECK_EN
    pulse_rst();
    begin
      int n;
      bit got;
      @(negedge clk);
      mem_read = 1; mem_write = 1; mem_address = 32'h0000_0040; mem_wdata = '0;
      @(posedge clk); #1;
      check("rw_error_set", {255'd0, mem_error}, 256'd1);
      n = 1; got = mem_resp;
      while (!got && n < 3 * LAT + 10) begin
        @(posedge clk); #1;
        n++;
        if (mem_resp) got = 1;
      end
      check("rw_latency", 256'(n), 256'(LAT));
      check("rw_rdata", mem_rdata, 256'd0);
      @(negedge clk); mem_read = 0; mem_write = 0;
      @(negedge clk);
      do_op(1, 0, 32'h0000_0040, 256'd0, c_a5, "rw_unchanged");
      check("rw_error_sticky", {255'd0, mem_error}, 256'd1);
      pulse_rst();
      check("rw_error_cleared", {255'd0, mem_error}, 256'd0);

      @(negedge clk);
      mem_read = 1; mem_address = 32'h0000_0040;
      @(posedge clk);
      @(negedge clk); mem_read = 0;
      @(posedge clk); #1;
      check("drop_error_set", {255'd0, mem_error}, 256'd1);
      n = 0; got = 0;
      while (!got && n < 3 * LAT + 10) begin
        if (mem_resp) got = 1;
        else begin
          @(posedge clk); #1;
          n++;
        end
      end
      check("drop_resp_seen", {255'd0, got}, 256'd1);
      if (got) check("drop_rdata", mem_rdata, c_a5);
      repeat (3) @(negedge clk);
    end
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
